mul_unsigned_acc: RTL and testbench
===================================

// Module: mul_unsigned_acc
// PURPOSE
// Downstream stage of mul_unsigned_pipeline: consumes its 2*WIDTH-bit unsigned products and
// sums each group of LEN consecutive valid products (dot-product accumulate).
// Each group sum goes out on a valid/ready port into a one-deep output buffer.
// The multiplier cannot stall, so there is no input ready. A result that cannot be buffered
// is dropped and flagged.
// PARAMETERS
// WIDTH  8  operand width of the upstream multiplier; products are 2*WIDTH bits
// LEN    4  products per group, >=2
// ACC_W  2*WIDTH+$clog2(LEN)  accumulator/result width; derived, never overridden, cannot wrap
// PORTS
// clk       in   1        rising-edge clock
// rst_n     in   1        asynchronous active-low reset
// clr       in   1        sync abort of the partial group (acc and count to 0)
// in_valid  in   1        in_z carries a product this cycle (delay-matched to multiplier latency)
// in_z      in   2*WIDTH  unsigned product
// out_valid out  1        out_sum holds a completed group sum
// out_ready in   1        consumer accepts out_sum when out_valid&&out_ready
// out_sum   out  ACC_W    group sum, stable while out_valid&&!out_ready
// drop_err  out  1        sticky: a completed group was lost; cleared only by rst_n
// busy      out  1        partial group in progress (cnt!=0)
// BEHAVIOUR
// - Reset (async, rst_n=0): acc=0, cnt=0, out_valid=0, out_sum=0, drop_err=0, busy=0.
// - Accumulator FSM:
//   - IDLE (cnt==0) -> ACC on in_valid.
//   - ACC counts 1..LEN-1; on the LEN-th valid it returns to IDLE.
//   - Non-final valid: acc<=acc+in_z, cnt<=cnt+1.
//   - Final valid (cnt==LEN-1): result=acc+in_z (ACC_W bits, zero-extended add).
//     Then acc<=0 and cnt<=0 in the same cycle, so the next group may start on the next cycle.
//   - in_valid=0: acc and cnt hold.
// - Latency: out_valid rises the cycle after the final product's edge (1 clk).
//   Back-to-back groups are sustained at full rate.
// - Output buffer (EMPTY/FULL):
//   - Result while EMPTY: load it; out_valid<=1.
//   - Handshake with no new result: out_valid<=0; out_sum keeps its last value.
//   - Result and handshake in the same cycle: load the new result; out_valid stays 1;
//     no error is raised.
//   - Result while FULL and !out_ready: the new result is discarded and drop_err<=1.
//     The buffered out_sum is unchanged.
// - clr:
//   - Has priority over in_valid. A product in the same cycle as clr is discarded, and so is
//     a final product.
//   - Does not affect the output buffer or drop_err.
// - busy = (cnt!=0), registered state.
// - Reset mid-group or mid-handshake: everything returns to reset values immediately.
//   The partial sum and the buffered result are lost and no error is flagged.
// - No X propagation: in_z is ignored when in_valid=0.
// STRUCTURE
// - Package mul_unsigned_pkg:
//   - acc_width(WIDTH,LEN) function.
//   - State localparams ST_IDLE/ST_ACC and OB_EMPTY/OB_FULL.
//   - Shared with the multiplier and this block's bench.
// - One sub-module, mul_acc_outbuf: the one-deep valid/ready holding register with drop
//   detect (load, ready, valid, data, drop).
// - Top level holds the cnt/acc datapath and the FSM.
// TESTING (WIDTH=8, LEN=4, out_ready=1 unless stated)
// 1. Products 16129,65025,28413,23 on consecutive cycles -> one cycle later out_valid=1,
//    out_sum=109590, drop_err=0.
// 2. Four products of 65025 -> out_sum=260100 (max, no wrap in 18 bits).
//    Immediately followed by four of 1 -> next out_sum=4, back-to-back, no gap cycle.
// 3. out_ready=0; group A (4x100) then group B (4x7) -> out_sum=400 held, drop_err=1.
//    Then out_ready=1 -> 400 accepted, out_valid falls, drop_err stays 1.
// 4. Two products of 50, then clr together with a third product of 50, then 4x500
//    -> out_sum=2000 (the earlier 100 and the product sent with clr are discarded);
//    busy=0 after clr.
// 5. Group 1 complete and held (out_ready=0). Group 2 final product arrives in the same
//    cycle out_ready=1 -> out_valid stays 1, out_sum switches to group-2 sum, drop_err=0.
// 6. Two products into a group, then pulse rst_n low mid-cycle -> all outputs 0 at once.
//    A new 4x3 group then yields out_sum=12.

Source files
------------

// File: rtl/mul_unsigned_pkg.sv
// Shared definitions for the unsigned multiplier family: result-width helper and
// state encodings for the accumulator and its output buffer.
package mul_unsigned_pkg;

    // Width that holds LEN products of 2*WIDTH bits without wrapping.
    function automatic int unsigned acc_width(input int unsigned width, input int unsigned len);
        return 2 * width + $clog2(len);
    endfunction

    typedef enum logic {
        ST_IDLE,
        ST_ACC
    } acc_state_t;

    typedef enum logic {
        OB_EMPTY,
        OB_FULL
    } ob_state_t;

endpackage

// File: rtl/mul_acc_outbuf.sv
// One-deep valid/ready holding register. A load that arrives while full and not
// draining is discarded and raises the sticky drop flag.
module mul_acc_outbuf
    import mul_unsigned_pkg::*;
#(
    parameter int unsigned W = 18
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         drop
);

    ob_state_t state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OB_EMPTY;
            data  <= '0;
            drop  <= 1'b0;
        end else begin
            case (state)
                OB_EMPTY: begin
                    if (load) begin
                        data  <= load_data;
                        state <= OB_FULL;
                    end
                end
                OB_FULL: begin
                    if (load) begin
                        // Draining this cycle frees the slot, so the new result replaces it.
                        if (ready) begin
                            data <= load_data;
                        end else begin
                            drop <= 1'b1;
                        end
                    end else if (ready) begin
                        state <= OB_EMPTY;
                    end
                end
                default: state <= OB_EMPTY;
            endcase
        end
    end

    assign valid = (state == OB_FULL);

endmodule

// File: rtl/mul_unsigned_acc.sv
// Sums each group of LEN consecutive valid products from the multiplier and hands the
// group sum to a one-deep output buffer.
module mul_unsigned_acc
    import mul_unsigned_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned LEN   = 4,
    localparam int unsigned ACC_W = acc_width(WIDTH, LEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               in_valid,
    input  logic [2*WIDTH-1:0] in_z,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_sum,
    output logic               drop_err,
    output logic               busy
);

    localparam int unsigned CNT_W = $clog2(LEN);

    acc_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic             take;
    logic             grp_done;

    assign take     = in_valid && !clr;
    assign sum      = acc + ACC_W'(in_z);
    assign grp_done = take && (state == ST_ACC) && (cnt == CNT_W'(LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            acc   <= '0;
            busy  <= 1'b0;
        end else if (clr) begin
            state <= ST_IDLE;
            cnt   <= '0;
            acc   <= '0;
            busy  <= 1'b0;
        end else if (in_valid) begin
            case (state)
                ST_IDLE: begin
                    acc   <= ACC_W'(in_z);
                    cnt   <= CNT_W'(1);
                    busy  <= 1'b1;
                    state <= ST_ACC;
                end
                ST_ACC: begin
                    if (cnt == CNT_W'(LEN - 1)) begin
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        acc <= sum;
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    mul_acc_outbuf #(
        .W(ACC_W)
    ) u_outbuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (grp_done),
        .load_data(sum),
        .ready    (out_ready),
        .valid    (out_valid),
        .data     (out_sum),
        .drop     (drop_err)
    );

endmodule

// File: tb/tb_mul_unsigned_acc.sv
// Directed and random stimulus for mul_unsigned_acc, checked every cycle against a
// group-sum reference model.
module tb_mul_unsigned_acc;
    import mul_unsigned_pkg::*;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned LEN   = 4;
    localparam int unsigned ACC_W = acc_width(WIDTH, LEN);

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               clr = 1'b0;
    logic               in_valid = 1'b0;
    logic [2*WIDTH-1:0] in_z = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [ACC_W-1:0]   out_sum;
    logic               drop_err;
    logic               busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int unsigned     m_cnt;
    longint unsigned m_acc;
    longint unsigned m_out;
    bit              m_valid;
    bit              m_drop;

    mul_unsigned_acc #(
        .WIDTH(WIDTH),
        .LEN  (LEN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .in_valid (in_valid),
        .in_z     (in_z),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .drop_err (drop_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt   = 0;
        m_acc   = 0;
        m_out   = 0;
        m_valid = 0;
        m_drop  = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
        check({tag, ".sum"},   64'(out_sum),   m_out);
        check({tag, ".drop"},  64'(drop_err),  64'(m_drop));
        check({tag, ".busy"},  64'(busy),      64'(m_cnt != 0));
    endtask

    // One clock: apply inputs, advance the model with what the DUT saw at the edge, compare.
    task automatic step(input bit v, input int unsigned z, input bit c, input bit r, input string tag);
        bit              done;
        longint unsigned res;
        in_valid  = v;
        in_z      = v ? (2*WIDTH)'(z) : (2*WIDTH)'($urandom);
        clr       = c;
        out_ready = r;
        @(posedge clk);
        done = 0;
        res  = 0;
        if (c) begin
            m_cnt = 0;
            m_acc = 0;
        end else if (v) begin
            m_acc += longint'(z);
            m_cnt++;
            if (m_cnt == LEN) begin
                done  = 1;
                res   = m_acc;
                m_cnt = 0;
                m_acc = 0;
            end
        end
        if (done) begin
            if (!m_valid || r) begin
                m_out   = res;
                m_valid = 1;
            end else begin
                m_drop = 1;
            end
        end else if (m_valid && r) begin
            m_valid = 0;
        end
        #1;
        check_all(tag);
    endtask

    task automatic group(input int unsigned z, input bit r, input string tag);
        for (int i = 0; i < int'(LEN); i++) step(1, z, 0, r, tag);
    endtask

    initial begin
        int unsigned ts[4];
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: mixed products
        ts = '{16129, 65025, 28413, 23};
        foreach (ts[i]) step(1, ts[i], 0, 1, "t1");
        check("t1.const_sum", 64'(out_sum), 64'd109590);
        check("t1.const_valid", 64'(out_valid), 64'd1);

        // 2: maximum group then back-to-back small group
        group(65025, 1, "t2a");
        check("t2.max_sum", 64'(out_sum), 64'd260100);
        group(1, 1, "t2b");
        check("t2.b2b_sum", 64'(out_sum), 64'd4);
        check("t2.b2b_valid", 64'(out_valid), 64'd1);
        step(0, 0, 0, 1, "t2idle");

        // 4: clr discards partial group and the product sent with it
        step(1, 50, 0, 1, "t4");
        step(1, 50, 0, 1, "t4");
        step(1, 50, 1, 1, "t4clr");
        check("t4.busy_after_clr", 64'(busy), 64'd0);
        group(500, 1, "t4g");
        check("t4.sum", 64'(out_sum), 64'd2000);
        step(0, 0, 0, 1, "t4idle");

        // 5: group completes on the same cycle the held result drains
        group(9, 0, "t5a");
        for (int i = 0; i < int'(LEN) - 1; i++) step(1, 11, 0, 0, "t5b");
        step(1, 11, 0, 1, "t5fin");
        check("t5.valid", 64'(out_valid), 64'd1);
        check("t5.sum", 64'(out_sum), 64'd44);
        check("t5.drop", 64'(drop_err), 64'd0);
        step(0, 0, 0, 1, "t5idle");

        // 3: second group lost while the first is held
        group(100, 0, "t3a");
        group(7, 0, "t3b");
        check("t3.held_sum", 64'(out_sum), 64'd400);
        check("t3.drop", 64'(drop_err), 64'd1);
        step(0, 0, 0, 1, "t3drain");
        check("t3.valid_fall", 64'(out_valid), 64'd0);
        check("t3.drop_sticky", 64'(drop_err), 64'd1);

        // 6: asynchronous reset mid-group
        step(1, 3, 0, 1, "t6");
        step(1, 3, 0, 1, "t6");
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t6rst");
        #1;
        rst_n = 1'b1;
        group(3, 1, "t6g");
        check("t6.sum", 64'(out_sum), 64'd12);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 65535),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
